// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO read-side stream drainer.
package fifo_rd_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer; the head entry is held in registers so the
// downstream payload never depends combinationally on the downstream ready.
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_head_last
);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic                  r_head_last;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  r_tail_last;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (i_clear) begin
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head_data <= i_data;
            r_head_last <= i_last;
          end else begin
            r_tail_data <= i_data;
            r_tail_last <= i_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head_data <= r_tail_data;
          r_head_last <= r_tail_last;
          r_occ       <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_head_data <= i_data;
            r_head_last <= i_last;
          end else begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            r_tail_data <= i_data;
            r_tail_last <= i_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_head_data;
  assign o_head_last = r_head_last;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-clock-domain drainer: FIFO reads with 1-cycle latency into a valid/ready stream.
// Define FIFO_RD_BURST_EN for almost-empty gated, packet-sized read bursts.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  FIFO_RD_CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  FLUSH_REQ,
  output logic                  FIFO_RD_ENA,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_RD_LAST,
  input  logic                  FIFO_RD_EMPTY,
  input  logic                  FIFO_RD_ALM_EMPTY,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST,
  output logic                  FLUSH_DONE,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  WORD_CNT,
  output logic [CNT_WIDTH-1:0]  PKT_CNT
);

  rd_state_e             r_state;
  rd_state_e             w_state_next;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic [1:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_flush_req;
  logic                  w_flush_end;
  logic [2:0]            w_pending;
  logic                  w_rd_ena;
  logic                  w_go;
  logic                  w_stop;
  logic                  w_burst_end;

`ifdef FIFO_RD_BURST_EN
  // The LAST word is visible on the FIFO bus while in flight, so the read
  // behind it is suppressed and the burst ends exactly on the packet boundary.
  assign w_burst_end = r_inflight && FIFO_RD_LAST;
  assign w_go        = ENABLE && !FIFO_RD_ALM_EMPTY;
  assign w_stop      = !ENABLE || w_burst_end;
`else
  logic w_unused_alm_empty;
  assign w_unused_alm_empty = FIFO_RD_ALM_EMPTY;
  assign w_burst_end        = 1'b0;
  assign w_go               = ENABLE;
  assign w_stop             = !ENABLE;
`endif

  assign M_VALID     = (w_occ != 2'd0);
  assign w_pop       = M_VALID && M_READY;
  assign w_flush_req = FLUSH_REQ && (r_state != FLUSH);
  assign w_flush_end = (r_state == FLUSH) && FIFO_RD_EMPTY && !r_inflight;
  assign w_push      = r_inflight && (r_state != FLUSH) && !w_flush_req;
  assign w_pending   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    w_rd_ena = 1'b0;
    case (r_state)
      STREAM:  w_rd_ena = !FIFO_RD_EMPTY && (w_pending < 3'd2) && !w_burst_end;
      FLUSH:   w_rd_ena = !FIFO_RD_EMPTY;
      default: w_rd_ena = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_flush_req)  w_state_next = FLUSH;
        else if (w_go)    w_state_next = STREAM;
      end
      STREAM: begin
        if (w_flush_req)  w_state_next = FLUSH;
        else if (w_stop)  w_state_next = IDLE;
      end
      FLUSH: begin
        if (w_flush_end)  w_state_next = IDLE;
      end
      default:            w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge FIFO_RD_CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_rd_ena;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        if (w_head_last) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (FIFO_RD_CLK),
    .i_rst_n     (RST_N),
    .i_clear     (w_flush_req),
    .i_push      (w_push),
    .i_data      (FIFO_RD_DATA),
    .i_last      (FIFO_RD_LAST),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last)
  );

  assign FIFO_RD_ENA = w_rd_ena;
  assign M_DATA      = w_head_data;
  assign M_LAST      = w_head_last;
  assign FLUSH_DONE  = w_flush_end;
  assign BUSY        = (r_state != IDLE) || (w_occ != 2'd0) || r_inflight;
  assign WORD_CNT    = r_word_cnt;
  assign PKT_CNT     = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO source plus expected-word tracking.
// Burst scenario is compiled only when FIFO_RD_BURST_EN is defined.
module tb_fifo_rd_stream;

  localparam int DW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          flush_req;
  logic          rd_ena;
  logic [DW-1:0] rd_data = '0;
  logic          rd_last = 1'b0;
  logic          rd_empty;
  logic          alm_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          flush_done;
  logic          busy;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] pkt_cnt;

  int checks    = 0;
  int errors    = 0;
  int exp_words = 0;
  int exp_pkts  = 0;

  // Behavioural source FIFO: words appended by the bench, popped on rd_ena.
  logic [DW:0] fmem [DEPTH];
  int f_wr = 0;
  int f_rd = 0;
  int ena_on_empty = 0;

  always #5 clk = ~clk;

  assign rd_empty = (f_rd == f_wr);

  always @(posedge clk) begin
    if (rd_ena) begin
      if (f_rd == f_wr) begin
        ena_on_empty <= ena_on_empty + 1;
      end else begin
        {rd_last, rd_data} <= fmem[f_rd];
        f_rd <= f_rd + 1;
      end
    end
  end

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .FIFO_RD_CLK       (clk),
    .RST_N             (rst_n),
    .ENABLE            (enable),
    .FLUSH_REQ         (flush_req),
    .FIFO_RD_ENA       (rd_ena),
    .FIFO_RD_DATA      (rd_data),
    .FIFO_RD_LAST      (rd_last),
    .FIFO_RD_EMPTY     (rd_empty),
    .FIFO_RD_ALM_EMPTY (alm_empty),
    .M_VALID           (m_valid),
    .M_READY           (m_ready),
    .M_DATA            (m_data),
    .M_LAST            (m_last),
    .FLUSH_DONE        (flush_done),
    .BUSY              (busy),
    .WORD_CNT          (word_cnt),
    .PKT_CNT           (pkt_cnt)
  );

  task automatic load(input logic [DW-1:0] d, input logic l);
    fmem[f_wr] = {l, d};
    f_wr++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; flush_req = 1'b0; m_ready = 1'b0; alm_empty = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
      errors++; $display("FAIL reset_mout valid=%b last=%b data=%h required all 0", m_valid, m_last, m_data);
    end
    checks++;
    if (rd_ena !== 1'b0) begin errors++; $display("FAIL reset_rd_ena got=%b required=0", rd_ena); end
    checks++;
    if (busy !== 1'b0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL reset_status busy=%b flush_done=%b required 0/0", busy, flush_done);
    end
    checks++;
    if (word_cnt !== '0 || pkt_cnt !== '0) begin
      errors++; $display("FAIL reset_counters words=%0d pkts=%0d required 0/0", word_cnt, pkt_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: checked outputs and counters after reset");
  endtask

  task automatic test_streaming();
    int hs;
    int last_cyc;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 512; i++) load(64'hFEDCBA98_76543210 + DW'(i), (i == 511));
    enable = 1'b1; m_ready = 1'b1;
    hs = 0; last_cyc = -1;
    for (int c = 0; c < 3000 && hs < 512; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        exp_d = 64'hFEDCBA98_76543210 + DW'(hs);
        checks++;
        if (m_data !== exp_d || m_last !== (hs == 511)) begin
          errors++; $display("FAIL stream_word idx=%0d got=%h/%b required=%h/%b", hs, m_data, m_last, exp_d, (hs == 511));
        end
        if (hs > 0) begin
          checks++;
          if (c != last_cyc + 1) begin
            errors++; $display("FAIL stream_rate idx=%0d gap=%0d cycles required=1", hs, c - last_cyc);
          end
        end
        last_cyc = c; hs++; exp_words++; if (hs == 512) exp_pkts++;
      end
    end
    checks++;
    if (hs != 512) begin errors++; $display("FAIL stream_timeout handshakes=%0d required=512", hs); end
    @(negedge clk);
    checks++;
    if (word_cnt !== CW'(512) || pkt_cnt !== CW'(1)) begin
      errors++; $display("FAIL stream_counters words=%0d pkts=%0d required 512/1", word_cnt, pkt_cnt);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle busy=%b required=0", busy); end
    $display("streaming: %0d words delivered", hs);
  endtask

  task automatic test_backpressure();
    logic [DW:0] ref_q[$];
    logic [DW:0] w;
    logic        prev_stall;
    logic [DW:0] prev_word;
    logic        pop;
    int reads;
    int hs;
    for (int i = 0; i < 64; i++) begin
      w = {(i == 63) || ($urandom_range(0, 7) == 0), $urandom, $urandom};
      load(w[DW-1:0], w[DW]);
      ref_q.push_back(w);
    end
    enable = 1'b1;
    reads = 0; hs = 0; prev_stall = 1'b0; prev_word = '0;
    for (int c = 0; c < 1000 && hs < 64; c++) begin
      @(negedge clk);
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== prev_word) begin
          errors++; $display("FAIL bp_stable valid=%b got=%h required=%h", m_valid, {m_last, m_data}, prev_word);
        end
      end
      pop = m_valid && m_ready;
      if (rd_ena) begin
        checks++;
        if (reads - hs - (pop ? 1 : 0) >= 2) begin
          errors++; $display("FAIL bp_overflow outstanding=%0d pop=%b required read only below 2", reads - hs, pop);
        end
        reads++;
      end
      if (pop) begin
        w = ref_q.pop_front();
        checks++;
        if ({m_last, m_data} !== w) begin
          errors++; $display("FAIL bp_word idx=%0d got=%h required=%h", hs, {m_last, m_data}, w);
        end
        hs++; exp_words++; if (w[DW]) exp_pkts++;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
    checks++;
    if (hs != 64) begin errors++; $display("FAIL bp_timeout handshakes=%0d required=64", hs); end
    @(negedge clk);
    m_ready = 1'b1;
    checks++;
    if (word_cnt !== CW'(exp_words) || pkt_cnt !== CW'(exp_pkts)) begin
      errors++; $display("FAIL bp_counters words=%0d pkts=%0d required %0d/%0d", word_cnt, pkt_cnt, exp_words, exp_pkts);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("backpressure: %0d words, %0d reads", hs, reads);
  endtask

  task automatic test_empty_boundary();
    int reads;
    int hs;
    logic [DW-1:0] d [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      load(d[i], 1'b0);
    end
    enable = 1'b1; m_ready = 1'b1;
    reads = 0; hs = 0;
    for (int c = 0; c < 200 && hs < 3; c++) begin
      @(negedge clk);
      if (rd_ena) begin
        reads++;
        checks++;
        if (rd_empty) begin errors++; $display("FAIL empty_read rd_ena=1 while empty, required 0"); end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== d[hs]) begin
          errors++; $display("FAIL empty_word idx=%0d got=%h required=%h", hs, m_data, d[hs]);
        end
        hs++; exp_words++;
        if (hs == 3) enable = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got=%b required=0 after 3rd handshake", busy); end
    for (int c = 0; c < 5; c++) begin
      if (rd_ena) reads++;
      @(negedge clk);
    end
    checks++;
    if (reads != 3 || hs != 3) begin
      errors++; $display("FAIL empty_reads reads=%0d handshakes=%0d required 3/3", reads, hs);
    end
    $display("empty_boundary: %0d reads, %0d handshakes", reads, hs);
  endtask

  task automatic test_flush();
    int dones;
    int valid_seen;
    for (int i = 0; i < 102; i++) load({$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    enable = 1'b1; m_ready = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || (f_wr - f_rd) != 100) begin
      errors++; $display("FAIL flush_prefill valid=%b fifo_left=%0d required 1/100", m_valid, f_wr - f_rd);
    end
    flush_req = 1'b1; enable = 1'b0;
    @(negedge clk);
    flush_req = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b required=0", m_valid); end
    dones = 0; valid_seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (flush_done) dones++;
      if (m_valid) valid_seen++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL flush_done_pulses got=%0d required=1", dones); end
    checks++;
    if (valid_seen != 0) begin errors++; $display("FAIL flush_valid_seen cycles=%0d required=0", valid_seen); end
    checks++;
    if (f_rd != f_wr) begin errors++; $display("FAIL flush_drain fifo_left=%0d required=0", f_wr - f_rd); end
    checks++;
    if (word_cnt !== CW'(exp_words) || pkt_cnt !== CW'(exp_pkts) || busy !== 1'b0) begin
      errors++; $display("FAIL flush_counters words=%0d pkts=%0d busy=%b required %0d/%0d/0",
                         word_cnt, pkt_cnt, busy, exp_words, exp_pkts);
    end
    $display("flush: %0d done pulses, fifo drained to %0d", dones, f_wr - f_rd);
  endtask

  task automatic test_reset_mid();
    int e;
    int hs;
    int total;
    e = f_wr;
    for (int i = 0; i < 40; i++) load({$urandom, $urandom}, 1'b0);
    enable = 1'b1; m_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 200 && hs < 10; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== fmem[e][DW-1:0]) begin
          errors++; $display("FAIL rstmid_word idx=%0d got=%h required=%h", hs, m_data, fmem[e][DW-1:0]);
        end
        e++; hs++;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || rd_ena !== 1'b0 || busy !== 1'b0 || m_data !== '0 || flush_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs valid=%b ena=%b busy=%b data=%h done=%b required all 0",
                         m_valid, rd_ena, busy, m_data, flush_done);
    end
    checks++;
    if (word_cnt !== '0 || pkt_cnt !== '0) begin
      errors++; $display("FAIL rstmid_counters words=%0d pkts=%0d required 0/0", word_cnt, pkt_cnt);
    end
    exp_words = 0; exp_pkts = 0;
    rst_n = 1'b1;
    e = f_rd;
    total = f_wr - e;
    hs = 0;
    for (int c = 0; c < 300 && hs < total; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== fmem[e][DW-1:0]) begin
          errors++; $display("FAIL rstmid_restart idx=%0d got=%h required=%h", hs, m_data, fmem[e][DW-1:0]);
        end
        e++; hs++; exp_words++;
      end
    end
    @(negedge clk);
    checks++;
    if (hs != total || word_cnt !== CW'(exp_words)) begin
      errors++; $display("FAIL rstmid_total handshakes=%0d words=%0d required %0d/%0d", hs, word_cnt, total, exp_words);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset_mid: %0d words after restart", hs);
  endtask

`ifdef FIFO_RD_BURST_EN
  task automatic test_burst();
    int r0;
    int ena_seen;
    int hs;
    logic last_ok;
    r0 = f_rd;
    for (int i = 0; i < 10; i++) load({$urandom, $urandom}, (i == 3));
    alm_empty = 1'b1; enable = 1'b1; m_ready = 1'b1;
    ena_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_ena) ena_seen++;
    end
    checks++;
    if (ena_seen != 0 || f_rd != r0) begin
      errors++; $display("FAIL burst_hold reads=%0d required=0 while almost-empty", f_rd - r0);
    end
    alm_empty = 1'b0;
    @(negedge clk);
    alm_empty = 1'b1;
    hs = 0; last_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if ({m_last, m_data} !== fmem[r0 + hs]) begin
          errors++; $display("FAIL burst_word idx=%0d got=%h required=%h", hs, {m_last, m_data}, fmem[r0 + hs]);
        end
        last_ok = m_last; hs++; exp_words++; if (m_last) exp_pkts++;
      end
    end
    checks++;
    if (f_rd - r0 != 4 || hs != 4 || !last_ok || busy !== 1'b0) begin
      errors++; $display("FAIL burst_extent reads=%0d handshakes=%0d last=%b busy=%b required 4/4/1/0",
                         f_rd - r0, hs, last_ok, busy);
    end
    enable = 1'b0;
    $display("burst: %0d words in burst", hs);
  endtask
`endif

  task automatic test_no_empty_reads();
    checks++;
    if (ena_on_empty != 0) begin
      errors++; $display("FAIL empty_strobes got=%0d required=0", ena_on_empty);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_reset_mid();
`ifdef FIFO_RD_BURST_EN
    test_burst();
`endif
    test_no_empty_reads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
